// File: rtl/periph_xfer_ctrl.sv
// periph_xfer_ctrl
// Single-shot APB master sequencer. A rising edge on the start level
// launches one APB transfer using the captured per_addr/per_data/wr.
// The transfer completes on pready or on a wait timeout. Completion is
// reported through done, status, rd_data and a sticky irq.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   start             transfer request level; a 0->1 edge launches a transfer
//   soft_rst          synchronous abort and clear, active-high
//   it_enable         allows irq to be raised when a transfer completes
//   wr                transfer direction (1 = write), captured with start
//   per_addr/per_data target address and write data, captured with start
//   m_p*              APB master interface
//   busy/done         transfer in flight / one-cycle completion pulse
//   rd_data           last successful read data
//   status            00 ok, 01 slave error, 10 timeout
//   dropped           sticky: a start edge arrived while busy
//   irq, irq_clr      sticky completion interrupt and its clear
//
// state  | meaning
// IDLE   | bus idle, waiting for a start edge
// SETUP  | APB setup phase (psel=1, penable=0), always one cycle
// ACCESS | APB access phase; waits on pready, counts wait cycles
// DONE   | completion reported (done pulse), bus released
//
// All outputs are registers. The comb process computes their next values.
// irq, status and rd_data update on the edge that enters DONE, so they
// become visible together with the done pulse.
module periph_xfer_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  soft_rst,
    input  logic                  it_enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] per_addr,
    input  logic [DATA_WIDTH-1:0] per_data,
    output logic                  m_psel,
    output logic                  m_penable,
    output logic                  m_pwrite,
    output logic [ADDR_WIDTH-1:0] m_paddr,
    output logic [DATA_WIDTH-1:0] m_pwdata,
    input  logic [DATA_WIDTH-1:0] m_prdata,
    input  logic                  m_pready,
    input  logic                  m_pslverr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [1:0]            status,
    output logic                  dropped,
    output logic                  irq,
    input  logic                  irq_clr
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SLVERR  = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    // The wait count equals the ACCESS cycle index. The last allowed index
    // is TIMEOUT-1, which gives exactly TIMEOUT ACCESS cycles.
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    state_t                state, state_nxt;
    logic                  start_q;
    logic                  start_edge;
    logic [7:0]            wait_cnt, wait_cnt_nxt;
    logic                  psel_nxt, penable_nxt, pwrite_nxt;
    logic [ADDR_WIDTH-1:0] paddr_nxt;
    logic [DATA_WIDTH-1:0] pwdata_nxt;
    logic                  busy_nxt, done_nxt, dropped_nxt, irq_nxt;
    logic [DATA_WIDTH-1:0] rd_data_nxt;
    logic [1:0]            status_nxt;
    logic                  irq_set, drop_set;

    assign start_edge = start & ~start_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            start_q   <= 1'b0;
            wait_cnt  <= '0;
            m_psel    <= 1'b0;
            m_penable <= 1'b0;
            m_pwrite  <= 1'b0;
            m_paddr   <= '0;
            m_pwdata  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            status    <= ST_OK;
            dropped   <= 1'b0;
            irq       <= 1'b0;
        end else begin
            state     <= state_nxt;
            start_q   <= start;
            wait_cnt  <= wait_cnt_nxt;
            m_psel    <= psel_nxt;
            m_penable <= penable_nxt;
            m_pwrite  <= pwrite_nxt;
            m_paddr   <= paddr_nxt;
            m_pwdata  <= pwdata_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            rd_data   <= rd_data_nxt;
            status    <= status_nxt;
            dropped   <= dropped_nxt;
            irq       <= irq_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        psel_nxt     = m_psel;
        penable_nxt  = m_penable;
        pwrite_nxt   = m_pwrite;
        paddr_nxt    = m_paddr;
        pwdata_nxt   = m_pwdata;
        busy_nxt     = busy;
        done_nxt     = 1'b0;
        rd_data_nxt  = rd_data;
        status_nxt   = status;
        dropped_nxt  = dropped;
        irq_nxt      = irq;
        irq_set      = 1'b0;
        drop_set     = 1'b0;

        if (soft_rst) begin
            // Abort wins over everything. A start edge in this cycle is lost
            // because start_q still follows start.
            state_nxt    = IDLE;
            wait_cnt_nxt = '0;
            psel_nxt     = 1'b0;
            penable_nxt  = 1'b0;
            busy_nxt     = 1'b0;
            rd_data_nxt  = '0;
            status_nxt   = ST_OK;
            dropped_nxt  = 1'b0;
            irq_nxt      = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        paddr_nxt   = per_addr;
                        pwdata_nxt  = per_data;
                        pwrite_nxt  = wr;
                        busy_nxt    = 1'b1;
                        psel_nxt    = 1'b1;
                        penable_nxt = 1'b0;
                        state_nxt   = SETUP;
                    end
                end
                SETUP: begin
                    penable_nxt  = 1'b1;
                    wait_cnt_nxt = '0;
                    state_nxt    = ACCESS;
                end
                ACCESS: begin
                    if (m_pready) begin
                        psel_nxt    = 1'b0;
                        penable_nxt = 1'b0;
                        done_nxt    = 1'b1;
                        irq_set     = it_enable;
                        state_nxt   = DONE;
                        if (m_pslverr) begin
                            status_nxt = ST_SLVERR;
                        end else begin
                            status_nxt = ST_OK;
                            if (!m_pwrite) begin
                                rd_data_nxt = m_prdata;
                            end
                        end
                    end else if (wait_cnt == WAIT_LAST) begin
                        psel_nxt    = 1'b0;
                        penable_nxt = 1'b0;
                        done_nxt    = 1'b1;
                        irq_set     = it_enable;
                        status_nxt  = ST_TIMEOUT;
                        state_nxt   = DONE;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 8'd1;
                    end
                end
                DONE: begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase

            drop_set    = start_edge & busy;
            // For both sticky flags, a set in the same cycle as irq_clr wins.
            dropped_nxt = drop_set | (dropped & ~irq_clr);
            irq_nxt     = irq_set | (irq & ~irq_clr);
        end
    end

endmodule

// File: tb/tb_periph_xfer_ctrl.sv
module tb_periph_xfer_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        soft_rst = 1'b0;
    logic        it_enable = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] per_addr = '0;
    logic [31:0] per_data = '0;
    logic        m_psel, m_penable, m_pwrite;
    logic [31:0] m_paddr, m_pwdata;
    logic [31:0] m_prdata = '0;
    logic        m_pready = 1'b0;
    logic        m_pslverr = 1'b0;
    logic        busy, done, dropped, irq;
    logic [31:0] rd_data;
    logic [1:0]  status;
    logic        irq_clr = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model of the software-visible result registers.
    logic [31:0] m_rd;
    logic [1:0]  m_status;
    bit          m_irq;
    bit          m_dropped;

    periph_xfer_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .soft_rst(soft_rst),
        .it_enable(it_enable), .wr(wr), .per_addr(per_addr), .per_data(per_data),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_pslverr(m_pslverr),
        .busy(busy), .done(done), .rd_data(rd_data), .status(status),
        .dropped(dropped), .irq(irq), .irq_clr(irq_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_results(input string where);
        chk({where, "_status"},  32'(status),    32'(m_status));
        chk({where, "_rd_data"}, rd_data,        m_rd);
        chk({where, "_irq"},     32'(irq),       32'(m_irq));
        chk({where, "_dropped"}, 32'(dropped),   32'(m_dropped));
    endtask

    // Runs one transfer, called at a negedge with the DUT idle.
    // t_wait: ACCESS cycles with pready low before pready rises.
    // t_retog: start re-raised in the first ACCESS cycle.
    // t_clr_last: irq_clr pulsed in the cycle whose edge completes the transfer.
    task automatic run_xfer(input bit t_wr, input logic [31:0] t_addr, input logic [31:0] t_data,
                            input int t_wait, input bit t_err, input logic [31:0] t_rdata,
                            input bit t_ien, input bit t_retog, input bit t_clr_last);
        bit tmo;
        int n_acc;
        tmo   = (t_wait > TMO - 1);
        n_acc = tmo ? TMO : t_wait + 1;
        per_addr  = t_addr;
        per_data  = t_data;
        wr        = t_wr;
        it_enable = t_ien;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        chk("setup_psel",    32'(m_psel),    32'd1);
        chk("setup_penable", 32'(m_penable), 32'd0);
        chk("setup_busy",    32'(busy),      32'd1);
        chk("setup_paddr",   m_paddr,        t_addr);
        chk("setup_pwrite",  32'(m_pwrite),  32'(t_wr));
        start    = 1'b0;
        per_addr = ~t_addr;
        per_data = ~t_data;
        wr       = ~t_wr;
        for (int k = 0; k < n_acc; k++) begin
            @(negedge clk);
            chk("acc_psel",    32'(m_psel),    32'd1);
            chk("acc_penable", 32'(m_penable), 32'd1);
            chk("acc_paddr",   m_paddr,        t_addr);
            chk("acc_pwdata",  m_pwdata,       t_data);
            chk("acc_pwrite",  32'(m_pwrite),  32'(t_wr));
            chk("acc_done",    32'(done),      32'd0);
            m_pready  = (k >= t_wait);
            m_pslverr = m_pready ? t_err : 1'($urandom);
            m_prdata  = m_pready ? t_rdata : $urandom;
            if (t_retog && k == 0) start = 1'b1;
            if (t_clr_last && k == n_acc - 1) irq_clr = 1'b1;
        end
        @(negedge clk);
        irq_clr   = 1'b0;
        m_pready  = 1'b0;
        m_pslverr = 1'b0;
        start     = 1'b0;
        if (tmo) m_status = 2'b10;
        else if (t_err) m_status = 2'b01;
        else begin
            m_status = 2'b00;
            if (!t_wr) m_rd = t_rdata;
        end
        m_irq = t_ien | (m_irq & ~t_clr_last);
        if (t_clr_last) m_dropped = t_retog && (n_acc == 1);
        else m_dropped = m_dropped | t_retog;
        chk("done_pulse",   32'(done),      32'd1);
        chk("done_psel",    32'(m_psel),    32'd0);
        chk("done_penable", 32'(m_penable), 32'd0);
        chk("done_busy",    32'(busy),      32'd1);
        chk_results("done");
        @(negedge clk);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_psel", 32'(m_psel), 32'd0);
        chk_results("idle");
    endtask

    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr   = 1'b0;
        m_irq     = 1'b0;
        m_dropped = 1'b0;
        chk("clr_irq",     32'(irq),     32'd0);
        chk("clr_dropped", 32'(dropped), 32'd0);
    endtask

    task automatic clear_model();
        m_rd = '0;
        m_status = 2'b00;
        m_irq = 1'b0;
        m_dropped = 1'b0;
    endtask

    initial begin
        clear_model();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_psel",    32'(m_psel),    32'd0);
        chk("rst_penable", 32'(m_penable), 32'd0);
        chk("rst_pwrite",  32'(m_pwrite),  32'd0);
        chk("rst_paddr",   m_paddr,        32'd0);
        chk("rst_pwdata",  m_pwdata,       32'd0);
        chk("rst_busy",    32'(busy),      32'd0);
        chk("rst_done",    32'(done),      32'd0);
        chk_results("rst");
        reset = 1'b1;
        @(negedge clk);

        // Write, zero wait states, irq enabled.
        run_xfer(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        pulse_irq_clr();
        // Read with three wait states.
        run_xfer(1'b0, 32'h24, 32'h0, 3, 1'b0, 32'h12345678, 1'b0, 1'b0, 1'b0);
        // Timeout: pready never rises.
        run_xfer(1'b0, 32'h30, 32'h0, 100, 1'b0, 32'hAAAA5555, 1'b0, 1'b0, 1'b0);
        // pready arrives exactly in the last allowed ACCESS cycle.
        run_xfer(1'b0, 32'h34, 32'h0, TMO - 1, 1'b0, 32'h0BADF00D, 1'b0, 1'b0, 1'b0);
        // Slave error on read: rd_data unchanged.
        run_xfer(1'b0, 32'h38, 32'h0, 0, 1'b1, 32'hFFFF0000, 1'b0, 1'b0, 1'b0);
        // Start retoggled during ACCESS, then clear.
        run_xfer(1'b1, 32'h40, 32'h11112222, 2, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        pulse_irq_clr();
        // irq_clr in the completing cycle: set wins.
        run_xfer(1'b1, 32'h44, 32'h3, 1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);

        // soft_rst in ACCESS after making every result register non-zero.
        run_xfer(1'b0, 32'h48, 32'h0, 2, 1'b0, 32'hCAFEF00D, 1'b1, 1'b0, 1'b0);
        run_xfer(1'b1, 32'h4C, 32'h5, 30, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        per_addr = 32'h50;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("sr_pre_penable", 32'(m_penable), 32'd1);
        soft_rst = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        clear_model();
        chk("sr_psel",    32'(m_psel),    32'd0);
        chk("sr_penable", 32'(m_penable), 32'd0);
        chk("sr_busy",    32'(busy),      32'd0);
        chk("sr_done",    32'(done),      32'd0);
        chk_results("sr");
        @(negedge clk);
        chk("sr_done2", 32'(done), 32'd0);
        // A start edge coincident with soft_rst is discarded; start held high
        // afterwards is no longer an edge.
        soft_rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        soft_rst = 1'b0;
        chk("sr_edge_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("sr_hold_busy", 32'(busy),   32'd0);
        chk("sr_hold_psel", 32'(m_psel), 32'd0);
        start = 1'b0;
        @(negedge clk);

        // Asynchronous reset in ACCESS.
        run_xfer(1'b0, 32'h60, 32'h0, 0, 1'b0, 32'h76543210, 1'b1, 1'b1, 1'b0);
        per_addr = 32'h64;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("ar_pre_psel", 32'(m_psel), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("ar_psel_async",    32'(m_psel),    32'd0);
        chk("ar_penable_async", 32'(m_penable), 32'd0);
        chk("ar_busy_async",    32'(busy),      32'd0);
        clear_model();
        @(negedge clk);
        chk("ar_done",  32'(done),    32'd0);
        chk("ar_paddr", m_paddr,      32'd0);
        chk_results("ar");
        reset = 1'b1;
        @(negedge clk);

        // Randomized transfers against the model.
        for (int n = 0; n < 40; n++) begin
            run_xfer(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 20)),
                     1'($urandom_range(0, 3) == 0), $urandom, 1'($urandom),
                     1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) pulse_irq_clr();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
